// File: rtl/pp_accum_pkg.sv
// Shared constants and state encoding for the radix-4 Booth partial-product accumulator.
package pp_accum_pkg;

    localparam int PP_W       = 16;
    localparam int NUM_PP     = 4;
    localparam int SHIFT_STEP = 2;
    localparam int CNT_W      = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pp_accum_if.sv
// Beat handshake and product result bundle between the partial-product source and the accumulator.
interface pp_accum_if;
    import pp_accum_pkg::*;

    logic            abort;
    logic [PP_W-1:0] pp_in;
    logic            pp_valid;
    logic            pp_ready;
    logic [PP_W-1:0] product;
    logic            prod_valid;
    logic            busy;

    modport master (
        output abort, pp_in, pp_valid,
        input  pp_ready, product, prod_valid, busy
    );

    modport slave (
        input  abort, pp_in, pp_valid,
        output pp_ready, product, prod_valid, busy
    );

endinterface

// File: rtl/pp_accum_shift_add.sv
// Combinational weight-and-add: aligns the current partial product to its radix-4 position and adds it.
module pp_shift_add
    import pp_accum_pkg::*;
(
    input  logic [PP_W-1:0]  pp_in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [PP_W-1:0]  acc,
    output logic [PP_W-1:0]  term,
    output logic [PP_W-1:0]  acc_next
);

    // Bits shifted past the product width are dropped; the sum wraps modulo 2^PP_W.
    always_comb begin
        term     = pp_in << (SHIFT_STEP * int'(cnt));
        acc_next = acc + term;
    end

endmodule

// File: rtl/pp_accum.sv
// Serial partial-product accumulator: folds NUM_PP shifted beats into one product and strobes it.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no beat of the current product accepted yet; acc=0, cnt=0
//   ST_ACC  | 1..NUM_PP-1 beats accepted, waiting for the next beat
//   ST_DONE | product just updated; prod_valid high, beats refused
module pp_accum
    import pp_accum_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    pp_accum_if.slave   bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PP_W-1:0]    acc_q, acc_d;
    logic [PP_W-1:0]    product_q, product_d;
    logic               prod_valid_q, prod_valid_d;
    logic [PP_W-1:0]    term;
    logic [PP_W-1:0]    acc_next;
    logic               pp_ready;
    logic               accept;
    logic               last_beat;

    pp_shift_add u_shift_add (
        .pp_in    (bus.pp_in),
        .cnt      (cnt_q),
        .acc      (acc_q),
        .term     (term),
        .acc_next (acc_next)
    );

    // Ready depends on state alone so the upstream never sees a combinational path from abort/valid.
    assign pp_ready  = (state_q != ST_DONE);
    assign accept    = bus.pp_valid && pp_ready;
    assign last_beat = (cnt_q == CNT_W'(NUM_PP - 1));

    // Next-state and datapath updates; abort outranks a same-cycle accept outside DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        product_d    = product_q;
        prod_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.abort) begin
                    cnt_d = '0;
                    acc_d = '0;
                end else if (accept) begin
                    acc_d   = term;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (last_beat) begin
                        product_d    = acc_next;
                        prod_valid_d = 1'b1;
                        acc_d        = '0;
                        cnt_d        = '0;
                        state_d      = ST_DONE;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                acc_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including any half-built product.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            product_q    <= '0;
            prod_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            product_q    <= product_d;
            prod_valid_q <= prod_valid_d;
        end
    end

    assign bus.pp_ready   = pp_ready;
    assign bus.product    = product_q;
    assign bus.prod_valid = prod_valid_q;
    assign bus.busy       = (state_q == ST_ACC) || (state_q == ST_DONE);

endmodule
